// File: rtl/snn_ctrl_pkg.sv
// Shared state encoding and default sizing for the SNN macro controller family.
package snn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int MACRO_LAT       = 4;
  localparam int DEF_NUM_NEURONS = 16;
  localparam int DEF_SPIKE_W     = 256;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_TIMEOUT     = 15;

endpackage

// File: rtl/spike_count_bank.sv
// Bank of saturating per-neuron fire counters with synchronous clear,
// presented as one flattened vector (neuron i at [i*CNT_W +: CNT_W]).
module spike_count_bank
  import snn_ctrl_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clr,
  input  logic                         i_inc,
  input  logic [NUM_NEURONS-1:0]       i_hits,
  output logic [NUM_NEURONS*CNT_W-1:0] o_count
);

  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_cnt <= '0;
      end else if (i_clr) begin
        r_cnt <= '0;
      end else if (i_inc && i_hits[gi] && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign o_count[gi*CNT_W +: CNT_W] = r_cnt;
  end

endmodule

// File: rtl/snn_timestep_sequencer.sv
// Time-step controller for one CIM inference macro: feeds spike frames,
// pulses EN/FT, collects NEURON_OUT on REQ and reports per-neuron fire counts.
module snn_timestep_sequencer
  import snn_ctrl_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int SPIKE_W     = DEF_SPIKE_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                         i_clk,
  input  logic                         i_rstb,
  input  logic                         i_start,
  input  logic [7:0]                   i_t_steps,
  input  logic                         i_s_valid,
  output logic                         o_s_ready,
  input  logic [SPIKE_W-1:0]           i_s_data,
  input  logic                         i_ms,
  output logic                         o_en,
  output logic                         o_ft,
  output logic [SPIKE_W-1:0]           o_spike_remap,
  input  logic                         i_req,
  input  logic [NUM_NEURONS-1:0]       i_neuron_out,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [NUM_NEURONS*CNT_W-1:0] o_out_count,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  seq_state_t         r_state;
  logic [7:0]         r_t_steps;
  logic [7:0]         r_step;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_en;
  logic               r_ft;
  logic               r_err;
  logic [SPIKE_W-1:0] r_spike;

  logic               w_accept;
  logic               w_count_inc;
  logic [7:0]         w_step_next;

  assign w_accept    = (r_state == IDLE) && i_start && !i_ms && (i_t_steps != 8'd0);
  assign w_count_inc = (r_state == WAIT) && i_req && !i_ms;
  assign w_step_next = r_step + 8'd1;

  // MS gates the pulse so the macro never sees EN/FT while in memory mode.
  assign o_en          = r_en & ~i_ms;
  assign o_ft          = r_ft & ~i_ms;
  assign o_s_ready     = (r_state == FETCH);
  assign o_out_valid   = (r_state == DONE);
  assign o_busy        = (r_state != IDLE);
  assign o_err         = r_err;
  assign o_spike_remap = r_spike;

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_state   <= IDLE;
      r_t_steps <= '0;
      r_step    <= '0;
      r_tmo     <= '0;
      r_en      <= 1'b0;
      r_ft      <= 1'b0;
      r_err     <= 1'b0;
      r_spike   <= '0;
    end else begin
      r_en <= 1'b0;
      r_ft <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_t_steps <= i_t_steps;
            r_step    <= '0;
            r_err     <= 1'b0;
            r_state   <= FETCH;
          end
        end
        FETCH: begin
          if (i_ms) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else if (i_s_valid) begin
            r_spike <= i_s_data;
            r_en    <= 1'b1;
            r_ft    <= (r_step == 8'd0);
            r_tmo   <= '0;
            r_state <= WAIT;
          end
        end
        // The timeout counter is zero in the EN cycle, so expiry lands at EN+TIMEOUT.
        WAIT: begin
          if (i_ms) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else if (i_req) begin
            r_step  <= w_step_next;
            r_state <= (w_step_next == r_t_steps) ? DONE : FETCH;
          end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  spike_count_bank #(
    .NUM_NEURONS (NUM_NEURONS),
    .CNT_W       (CNT_W)
  ) u_count_bank (
    .i_clk   (i_clk),
    .i_rst_n (i_rstb),
    .i_clr   (w_accept),
    .i_inc   (w_count_inc),
    .i_hits  (i_neuron_out),
    .o_count (o_out_count)
  );

endmodule
